issue_scoreboard_ctrl: RTL

- Sequences decoded instructions from the ID-stage decoder into the execute stage.
- Holds one decoded instruction in an output register. Tracks pending register writes in a 32-entry scoreboard. Stalls issue on RAW and WAW hazards.
- Supports a branch/jump flush.
- Sits between the decoder's registered outputs and the EX-stage input; writeback reports completions back to it.

---
 rtl/issue_scoreboard_ctrl_pkg.sv | 23 ++
 rtl/issue_scoreboard_ctrl_reg_scoreboard.sv | 29 ++
 rtl/issue_scoreboard_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/issue_scoreboard_ctrl_pkg.sv
// issue_scoreboard_ctrl_pkg: shared CPU types, operation codes and register-mask helper
package issue_scoreboard_ctrl_pkg;
    localparam int REG_COUNT = 32;
    localparam int OPER_W = 6;
    typedef logic [OPER_W-1:0] oper_t;
    typedef logic [4:0] regaddr_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    localparam oper_t OP_NOP = 6'd0;
    localparam oper_t OP_ADD = 6'd1;
    localparam oper_t OP_SUB = 6'd2;
    localparam oper_t OP_AND = 6'd3;
    localparam oper_t OP_OR  = 6'd4;
    localparam oper_t OP_LW  = 6'd5;
    localparam oper_t OP_SW  = 6'd6;
    localparam oper_t OP_BEQ = 6'd7;
    localparam oper_t OP_JAL = 6'd8;
    // one-hot mask of register a when en is set; x0 never produces a bit
    function automatic logic [REG_COUNT-1:0] reg_mask(input logic en, input regaddr_t a);
        reg_mask = '0;
        reg_mask[a] = en && (a != '0);
    endfunction
endpackage

// File: rtl/issue_scoreboard_ctrl_reg_scoreboard.sv
// reg_scoreboard: pending-write busy vector with writeback/flush clears, issue set and 3-port lookup
module reg_scoreboard
    import issue_scoreboard_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_en,
    input  regaddr_t             set_addr,
    input  logic                 clr_en,
    input  regaddr_t             clr_addr,
    input  logic                 kill_en,
    input  regaddr_t             kill_addr,
    input  regaddr_t             look0,
    input  regaddr_t             look1,
    input  regaddr_t             look2,
    output logic [2:0]           look_busy,
    output logic [REG_COUNT-1:0] busy
);
    logic [REG_COUNT-1:0] eff_busy;

    assign eff_busy  = busy & ~reg_mask(clr_en, clr_addr);
    assign look_busy = {eff_busy[look2], eff_busy[look1], eff_busy[look0]};

    // clears apply first so a same-cycle issue to the same register wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (eff_busy & ~reg_mask(kill_en, kill_addr)) | reg_mask(set_en, set_addr);
    end
endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// issue_scoreboard_ctrl: holds one decoded instruction for EX, stalling on RAW/WAW hazards
module issue_scoreboard_ctrl
    import issue_scoreboard_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  addr_t                  in_pc,
    input  logic [OP_W-1:0]        in_op,
    input  word_t                  in_imm,
    input  regaddr_t               in_rs0,
    input  regaddr_t               in_rs1,
    input  regaddr_t               in_rd,
    input  logic                   in_use_rs0,
    input  logic                   in_use_rs1,
    input  logic                   in_wr_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output addr_t                  out_pc,
    output logic [OP_W-1:0]        out_op,
    output word_t                  out_imm,
    output regaddr_t               out_rs0,
    output regaddr_t               out_rs1,
    output regaddr_t               out_rd,
    output logic                   out_wr_rd,
    input  logic                   wb_valid,
    input  regaddr_t               wb_rd,
    input  logic                   flush,
    output logic [REG_COUNT-1:0]   busy_map,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic [2:0] look_busy;
    logic       hazard;
    logic       accept;
    logic       kill;

    assign hazard   = (in_use_rs0 && in_rs0 != '0 && look_busy[0])
                   || (in_use_rs1 && in_rs1 != '0 && look_busy[1])
                   || (in_wr_rd   && in_rd  != '0 && look_busy[2]);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign kill     = flush && out_valid && !out_ready && out_wr_rd;

    reg_scoreboard u_sb (
        .clock     (clock),
        .reset     (reset),
        .set_en    (accept && in_wr_rd),
        .set_addr  (in_rd),
        .clr_en    (wb_valid),
        .clr_addr  (wb_rd),
        .kill_en   (kill),
        .kill_addr (out_rd),
        .look0     (in_rs0),
        .look1     (in_rs1),
        .look2     (in_rd),
        .look_busy (look_busy),
        .busy      (busy_map)
    );

    // output register: load on accept, drop when consumed or flushed, otherwise hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op    <= '0;
            out_imm   <= '0;
            out_rs0   <= '0;
            out_rs1   <= '0;
            out_rd    <= '0;
            out_wr_rd <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_op    <= in_op;
            out_imm   <= in_imm;
            out_rs0   <= in_rs0;
            out_rs1   <= in_rs1;
            out_rd    <= in_rd;
            out_wr_rd <= in_wr_rd;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // saturating count of cycles a presented instruction is held back by a hazard
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if (in_valid && hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
